// File: rtl/usb_tx_data_buffer.sv
// Byte FIFO between the AHB-Lite slave and the USB TX engine.
// Accepts 1/2/4-byte pushes and presents the head byte combinationally to usb_tx.
`timescale 1ns/1ps
module usb_tx_data_buffer #(
  parameter int DEPTH    = 64,
  parameter int PTR_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        store_tx_data,
  input  logic [1:0]  tx_write_size,
  input  logic [31:0] tx_write_data,
  input  logic        get_tx_packet_data,
  output logic [7:0]  tx_packet_data,
  output logic [6:0]  buffer_occupancy,
  output logic        buffer_full,
  output logic        buffer_empty,
  output logic        overflow_err,
  output logic        underflow_err
);

  logic [7:0]          mem_q [DEPTH];
  logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [6:0]          occ_q, occ_d;
  logic                ovf_q, ovf_d;
  logic                udf_q, udf_d;

  logic [2:0] push_len;
  logic [7:0] space;
  logic       push_ok;
  logic       pop_ok;
  logic [3:0] byte_we;

  always_comb begin
    push_len = 3'd0;
    case (tx_write_size)
      2'd0:    push_len = 3'd1;
      2'd1:    push_len = 3'd2;
      2'd2:    push_len = 3'd4;
      default: push_len = 3'd0;
    endcase

    // Space is judged on the occupancy before this cycle's pop.
    space   = 8'(DEPTH) - {1'b0, occ_q};
    push_ok = store_tx_data && !clear && (push_len != 3'd0) && (space >= {5'd0, push_len});
    pop_ok  = get_tx_packet_data && !clear && (occ_q != 7'd0);

    byte_we = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      byte_we[i] = push_ok && (3'(i) < push_len);
    end

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;

    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      occ_d    = 7'd0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (store_tx_data) begin
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_BITS'(push_len);
        else         ovf_d    = 1'b1;
      end
      if (get_tx_packet_data) begin
        if (pop_ok) rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
        else        udf_d    = 1'b1;
      end
      occ_d = occ_q + (push_ok ? 7'(push_len) : 7'd0) - (pop_ok ? 7'd1 : 7'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= 7'd0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is deliberately not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst && byte_we[i]) begin
        mem_q[wr_ptr_q + PTR_BITS'(i)] <= tx_write_data[8*i +: 8];
      end
    end
  end

  assign buffer_occupancy = occ_q;
  assign buffer_empty     = (occ_q == 7'd0);
  assign buffer_full      = (occ_q == 7'(DEPTH));
  assign overflow_err     = ovf_q;
  assign underflow_err    = udf_q;
  assign tx_packet_data   = buffer_empty ? 8'h00 : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_usb_tx_data_buffer.sv
// Directed self-checking bench for usb_tx_data_buffer: one task per scenario,
// expected values computed by hand or by a small queue model.
`timescale 1ns/1ps
module tb_usb_tx_data_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic        store_tx_data = 1'b0;
  logic [1:0]  tx_write_size = 2'd0;
  logic [31:0] tx_write_data = 32'd0;
  logic        get_tx_packet_data = 1'b0;
  logic [7:0]  tx_packet_data;
  logic [6:0]  buffer_occupancy;
  logic        buffer_full;
  logic        buffer_empty;
  logic        overflow_err;
  logic        underflow_err;

  int vectors = 0;
  int miscompares = 0;

  usb_tx_data_buffer #(.DEPTH(64), .PTR_BITS(6)) dut (
    .clk                (clk),
    .rst                (rst),
    .clear              (clear),
    .store_tx_data      (store_tx_data),
    .tx_write_size      (tx_write_size),
    .tx_write_data      (tx_write_data),
    .get_tx_packet_data (get_tx_packet_data),
    .tx_packet_data     (tx_packet_data),
    .buffer_occupancy   (buffer_occupancy),
    .buffer_full        (buffer_full),
    .buffer_empty       (buffer_empty),
    .overflow_err       (overflow_err),
    .underflow_err      (underflow_err)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] size, input logic [31:0] data);
    store_tx_data = 1'b1;
    tx_write_size = size;
    tx_write_data = data;
    tick();
    store_tx_data = 1'b0;
  endtask

  task automatic pop();
    get_tx_packet_data = 1'b1;
    tick();
    get_tx_packet_data = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (buffer_occupancy !== 7'd0) begin miscompares++; $display("[TB] FAIL reset_occ got %0d expected 0", buffer_occupancy); end
    vectors++;
    if (buffer_empty !== 1'b1 || buffer_full !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_flags got empty=%b full=%b expected empty=1 full=0", buffer_empty, buffer_full); end
    vectors++;
    if (overflow_err !== 1'b0 || underflow_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_errs got ovf=%b udf=%b expected 0 0", overflow_err, underflow_err); end
    vectors++;
    if (tx_packet_data !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_data got %h expected 00", tx_packet_data); end
  endtask

  task automatic test_four_byte();
    logic [7:0] exp_bytes [4];
    exp_bytes[0] = 8'hF0; exp_bytes[1] = 8'hA1; exp_bytes[2] = 8'hB2; exp_bytes[3] = 8'hC3;
    push(2'd2, 32'hC3B2A1F0);
    vectors++;
    if (buffer_occupancy !== 7'd4) begin miscompares++; $display("[TB] FAIL word_occ got %0d expected 4", buffer_occupancy); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (tx_packet_data !== exp_bytes[i]) begin miscompares++; $display("[TB] FAIL word_head%0d got %h expected %h", i, tx_packet_data, exp_bytes[i]); end
      // Head must hold still while usb_tx is shifting it out.
      tick();
      vectors++;
      if (tx_packet_data !== exp_bytes[i]) begin miscompares++; $display("[TB] FAIL word_stable%0d got %h expected %h", i, tx_packet_data, exp_bytes[i]); end
      pop();
    end
    vectors++;
    if (buffer_occupancy !== 7'd0 || buffer_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL word_drain got occ=%0d empty=%b expected 0 1", buffer_occupancy, buffer_empty); end
  endtask

  task automatic test_overflow();
    logic [7:0] b;
    pulse_clear();
    for (int i = 0; i < 15; i++) begin
      b = 8'(4 * i);
      push(2'd2, {b + 8'd3, b + 8'd2, b + 8'd1, b});
    end
    push(2'd1, {16'h0, 8'd61, 8'd60});
    push(2'd0, {24'h0, 8'd62});
    vectors++;
    if (buffer_occupancy !== 7'd63 || overflow_err !== 1'b0) begin miscompares++; $display("[TB] FAIL fill63 got occ=%0d ovf=%b expected 63 0", buffer_occupancy, overflow_err); end
    push(2'd1, 32'h0000_EEEE);
    vectors++;
    if (buffer_occupancy !== 7'd63 || overflow_err !== 1'b1) begin miscompares++; $display("[TB] FAIL reject2 got occ=%0d ovf=%b expected 63 1", buffer_occupancy, overflow_err); end
    push(2'd0, {24'h0, 8'd63});
    vectors++;
    if (buffer_occupancy !== 7'd64 || buffer_full !== 1'b1) begin miscompares++; $display("[TB] FAIL fill64 got occ=%0d full=%b expected 64 1", buffer_occupancy, buffer_full); end
    vectors++;
    if (tx_packet_data !== 8'd0) begin miscompares++; $display("[TB] FAIL full_head got %h expected 00", tx_packet_data); end
    store_tx_data = 1'b1; tx_write_size = 2'd0; tx_write_data = 32'h0000_00AA;
    get_tx_packet_data = 1'b1;
    tick();
    store_tx_data = 1'b0; get_tx_packet_data = 1'b0;
    vectors++;
    if (buffer_occupancy !== 7'd63 || overflow_err !== 1'b1 || buffer_full !== 1'b0) begin miscompares++; $display("[TB] FAIL full_pushpop got occ=%0d ovf=%b full=%b expected 63 1 0", buffer_occupancy, overflow_err, buffer_full); end
    vectors++;
    if (tx_packet_data !== 8'd1) begin miscompares++; $display("[TB] FAIL full_pop_head got %h expected 01", tx_packet_data); end
    pulse_clear();
    vectors++;
    if (buffer_occupancy !== 7'd0 || overflow_err !== 1'b0 || buffer_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL clear_after_full got occ=%0d ovf=%b empty=%b expected 0 0 1", buffer_occupancy, overflow_err, buffer_empty); end
  endtask

  task automatic test_underflow();
    pop();
    vectors++;
    if (underflow_err !== 1'b1 || buffer_occupancy !== 7'd0 || tx_packet_data !== 8'h00) begin miscompares++; $display("[TB] FAIL underflow got udf=%b occ=%0d data=%h expected 1 0 00", underflow_err, buffer_occupancy, tx_packet_data); end
    push(2'd3, 32'h1234_5678);
    vectors++;
    if (overflow_err !== 1'b1 || buffer_occupancy !== 7'd0) begin miscompares++; $display("[TB] FAIL size3 got ovf=%b occ=%0d expected 1 0", overflow_err, buffer_occupancy); end
    clear = 1'b1; store_tx_data = 1'b1; tx_write_size = 2'd2; tx_write_data = 32'h1111_1111;
    tick();
    clear = 1'b0; store_tx_data = 1'b0;
    vectors++;
    if (overflow_err !== 1'b0 || underflow_err !== 1'b0) begin miscompares++; $display("[TB] FAIL clear_errs got ovf=%b udf=%b expected 0 0", overflow_err, underflow_err); end
    vectors++;
    if (buffer_occupancy !== 7'd0) begin miscompares++; $display("[TB] FAIL clear_drops_push got occ=%0d expected 0", buffer_occupancy); end
  endtask

  task automatic test_wrap();
    logic [7:0] model [$];
    int pushed = 0;
    int popped = 0;
    int cyc = 0;
    logic do_push, do_pop;
    while (popped < 100 && cyc < 1000) begin
      do_push = (pushed < 100) && (model.size() < 10);
      do_pop  = (model.size() > 0) && (((cyc % 3) != 0) || (pushed == 100));
      store_tx_data = do_push; tx_write_size = 2'd0; tx_write_data = {24'h0, 8'(pushed + 8'h20)};
      get_tx_packet_data = do_pop;
      if (do_pop) begin
        vectors++;
        if (tx_packet_data !== model[0]) begin miscompares++; $display("[TB] FAIL wrap_byte%0d got %h expected %h", popped, tx_packet_data, model[0]); end
      end
      tick();
      if (do_pop) begin void'(model.pop_front()); popped++; end
      if (do_push) begin model.push_back(8'(pushed + 8'h20)); pushed++; end
      cyc++;
    end
    store_tx_data = 1'b0; get_tx_packet_data = 1'b0;
    vectors++;
    if (popped !== 100) begin miscompares++; $display("[TB] FAIL wrap_timeout got %0d pops expected 100", popped); end
    vectors++;
    if (buffer_occupancy !== 7'd0 || underflow_err !== 1'b0 || overflow_err !== 1'b0) begin miscompares++; $display("[TB] FAIL wrap_end got occ=%0d udf=%b ovf=%b expected 0 0 0", buffer_occupancy, underflow_err, overflow_err); end
  endtask

  task automatic test_reset_mid();
    push(2'd2, 32'h0403_0201);
    push(2'd2, 32'h0807_0605);
    push(2'd1, 32'h0000_0A09);
    vectors++;
    if (buffer_occupancy !== 7'd10) begin miscompares++; $display("[TB] FAIL mid_occ got %0d expected 10", buffer_occupancy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (buffer_occupancy !== 7'd0 || buffer_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_reset got occ=%0d empty=%b expected 0 1", buffer_occupancy, buffer_empty); end
    push(2'd0, 32'h0000_005A);
    vectors++;
    if (tx_packet_data !== 8'h5A || buffer_occupancy !== 7'd1) begin miscompares++; $display("[TB] FAIL mid_push got data=%h occ=%0d expected 5a 1", tx_packet_data, buffer_occupancy); end
  endtask

  initial begin
    test_reset();
    test_four_byte();
    test_overflow();
    test_underflow();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
